pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Central pipeline sequencer for the 5-stage RV32I core.
- Consumes the hazard conditions that operand forwarding cannot cover: load-use, taken branch/jump redirect, and data-memory wait.
- Drives stall (hold) and flush (bubble) enables for the PC, IF/ID, ID/EX and EX/MEM registers.
- Owns a small state machine for multi-cycle memory waits and redirect drain. Also provides a wait-timeout error flag and saturating performance counters.

Parameters:
- REGFILE_ADDR_WIDTH, 5, register address width.
- CNT_WIDTH, 16, width of the performance counters.
- MEM_TIMEOUT, 255, maximum consecutive wait cycles before mem_timeout_err is raised.
- REDIRECT_BUBBLES, 2, IF/ID flush cycles per redirect (1 or 2; 2 covers synchronous instruction memory).

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- ID_Rs1_addr  in  REGFILE_ADDR_WIDTH  rs1 of the instruction in ID.
- ID_Rs2_addr  in  REGFILE_ADDR_WIDTH  rs2 of the instruction in ID.
- ID_Rs1_used  in  1  the ID instruction reads rs1.
- ID_Rs2_used  in  1  the ID instruction reads rs2.
- EX_Rd_addr  in  REGFILE_ADDR_WIDTH  rd of the instruction in EX.
- EX_MemRead  in  1  the EX instruction is a load.
- EX_Redirect  in  1  a taken branch or jump has resolved in EX.
- MEM_dmem_req  in  1  MEM stage has an active data-memory access.
- MEM_dmem_ack  in  1  data memory completes the access this cycle.
- PC_stall  out  1  hold the PC.
- IFID_stall  out  1  hold the IF/ID register.
- IFID_flush  out  1  load a NOP into IF/ID.
- IDEX_stall  out  1  hold the ID/EX register.
- IDEX_flush  out  1  load a bubble into ID/EX.
- EXMEM_stall  out  1  hold the EX/MEM register.
- mem_timeout_err  out  1  sticky; set when a wait exceeds MEM_TIMEOUT.
- stall_cycles  out  CNT_WIDTH  saturating count of cycles with PC_stall=1.
- flush_events  out  CNT_WIDTH  saturating count of redirects accepted.

Behaviour:
- States: RUN, MEM_WAIT, DRAIN. Reset enters RUN.
- While rst=1: all stall/flush outputs 0, counters 0, mem_timeout_err 0, wait counter 0.
- Control outputs are combinational from the current state and current inputs, so they take effect at the next edge. Counters and state are registered.
- Hazard terms:
  - mw = MEM_dmem_req & ~MEM_dmem_ack.
  - lu = EX_MemRead & (EX_Rd_addr!=0) & ((ID_Rs1_used & EX_Rd_addr==ID_Rs1_addr) | (ID_Rs2_used & EX_Rd_addr==ID_Rs2_addr)).
- Priority order: mw > EX_Redirect > DRAIN > lu.
- mw (any state): PC_stall = IFID_stall = IDEX_stall = EXMEM_stall = 1, all flushes 0. Next state is MEM_WAIT. A pending redirect is held until the wait ends, not dropped.
- MEM_WAIT:
  - Increments the wait counter while mw is true.
  - On ack, returns to RUN and clears the counter. The ack cycle itself is not stalled.
  - When the counter reaches MEM_TIMEOUT, mem_timeout_err is set and stays set until rst. Stalling continues.
- EX_Redirect without mw:
  - IFID_flush = IDEX_flush = 1, all stalls 0.
  - flush_events increments.
  - If REDIRECT_BUBBLES=2, next state is DRAIN; otherwise stay in RUN.
- DRAIN (one cycle): IFID_flush = 1 only, then return to RUN. A new EX_Redirect in DRAIN is handled as a fresh redirect.
- lu in RUN without higher-priority terms: PC_stall = IFID_stall = 1, IDEX_flush = 1 (one bubble). lu clears by itself the next cycle because the load advances to MEM.
- lu in DRAIN is ignored; the ID slot is being flushed.
- x0 never creates a load-use hazard.
- stall_cycles increments on every cycle with PC_stall=1. Both counters saturate at all-ones and do not wrap.
- Reset asserted in MEM_WAIT or DRAIN returns to RUN on the same edge, with no residual flush.

Decomposition:
- Shared package `pipe_ctrl_pkg`:
  - state enum typedef (RUN, MEM_WAIT, DRAIN);
  - packed struct pipe_ctl_t {pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_stall};
  - constant NOP_INSTR = 32'h00000013.
- One natural sub-module: `sat_counter` (parameterised width, inc, clear), instantiated twice.
- The FSM and hazard decode stay in the top module.

Test Plan:
- lw x5 in EX (EX_MemRead=1, EX_Rd_addr=5), ID reads x5 (Rs1_used=1, Rs1_addr=5) → exactly 1 cycle of PC_stall=IFID_stall=IDEX_flush=1; stall_cycles=1. Repeat with Rd=0 → no stall.
- MEM_dmem_req=1, ack low for 4 cycles then high → all four stalls high for exactly 4 cycles; state returns to RUN on the ack cycle; stall_cycles=4.
- EX_Redirect pulse with REDIRECT_BUBBLES=2 → cycle 0: IFID_flush=IDEX_flush=1; cycle 1: IFID_flush only; flush_events=1.
- EX_Redirect together with mw for 3 cycles → no flush during the wait; flush asserted on the ack cycle; flush_events=1.
- MEM_TIMEOUT=8, ack never arrives → mem_timeout_err rises after the 8th wait cycle and stays set; rst=1 clears it and the state is RUN on the next cycle.
- CNT_WIDTH=4, 20 consecutive load-use stalls → stall_cycles holds at 15.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types and constants for the pipeline hazard controller
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_DRAIN    = 2'd2
    } hz_state_e;

    typedef struct packed {
        logic pc_stall;
        logic ifid_stall;
        logic ifid_flush;
        logic idex_stall;
        logic idex_flush;
        logic exmem_stall;
    } pipe_ctl_t;

    // addi x0, x0, 0 - what a flushed IF/ID slot holds
    localparam logic [31:0] NOP_INSTR = 32'h00000013;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    // Count up on inc, stick at all-ones instead of wrapping; clear wins.
    always_ff @(posedge clk) begin
        if (clear) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush sequencer for the 5-stage RV32I pipeline
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REGFILE_ADDR_WIDTH = 5,
    parameter int CNT_WIDTH          = 16,
    parameter int MEM_TIMEOUT        = 255,
    parameter int REDIRECT_BUBBLES   = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [REGFILE_ADDR_WIDTH-1:0] ID_Rs1_addr,
    input  logic [REGFILE_ADDR_WIDTH-1:0] ID_Rs2_addr,
    input  logic                          ID_Rs1_used,
    input  logic                          ID_Rs2_used,
    input  logic [REGFILE_ADDR_WIDTH-1:0] EX_Rd_addr,
    input  logic                          EX_MemRead,
    input  logic                          EX_Redirect,
    input  logic                          MEM_dmem_req,
    input  logic                          MEM_dmem_ack,
    output logic                          PC_stall,
    output logic                          IFID_stall,
    output logic                          IFID_flush,
    output logic                          IDEX_stall,
    output logic                          IDEX_flush,
    output logic                          EXMEM_stall,
    output logic                          mem_timeout_err,
    output logic [CNT_WIDTH-1:0]          stall_cycles,
    output logic [CNT_WIDTH-1:0]          flush_events
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam hz_state_e AFTER_REDIRECT = (REDIRECT_BUBBLES == 2) ? ST_DRAIN : ST_RUN;

    hz_state_e          state, state_nxt;
    pipe_ctl_t          ctl;
    logic [WAIT_W-1:0]  wait_cnt;
    logic               redirect_pending;
    logic               redirect_eff;
    logic               redirect_accept;
    logic               mw;
    logic               lu;
    logic               rs1_hit;
    logic               rs2_hit;

    assign mw      = MEM_dmem_req & ~MEM_dmem_ack;
    assign rs1_hit = ID_Rs1_used & (EX_Rd_addr == ID_Rs1_addr);
    assign rs2_hit = ID_Rs2_used & (EX_Rd_addr == ID_Rs2_addr);
    assign lu      = EX_MemRead & (EX_Rd_addr != '0) & (rs1_hit | rs2_hit);

    // A redirect seen during a memory wait is remembered so it is acted on once the wait ends.
    assign redirect_eff = EX_Redirect | redirect_pending;

    // Priority decode: memory wait, then redirect, then drain bubble, then load-use.
    always_comb begin
        ctl             = '0;
        state_nxt       = state;
        redirect_accept = 1'b0;
        if (rst) begin
            state_nxt = ST_RUN;
        end else if (mw) begin
            ctl.pc_stall    = 1'b1;
            ctl.ifid_stall  = 1'b1;
            ctl.idex_stall  = 1'b1;
            ctl.exmem_stall = 1'b1;
            state_nxt       = ST_MEM_WAIT;
        end else if (redirect_eff) begin
            ctl.ifid_flush  = 1'b1;
            ctl.idex_flush  = 1'b1;
            redirect_accept = 1'b1;
            state_nxt       = AFTER_REDIRECT;
        end else if (state == ST_DRAIN) begin
            ctl.ifid_flush = 1'b1;
            state_nxt      = ST_RUN;
        end else begin
            if (lu) begin
                ctl.pc_stall   = 1'b1;
                ctl.ifid_stall = 1'b1;
                ctl.idex_flush = 1'b1;
            end
            state_nxt = ST_RUN;
        end
    end

    assign PC_stall    = ctl.pc_stall;
    assign IFID_stall  = ctl.ifid_stall;
    assign IFID_flush  = ctl.ifid_flush;
    assign IDEX_stall  = ctl.idex_stall;
    assign IDEX_flush  = ctl.idex_flush;
    assign EXMEM_stall = ctl.exmem_stall;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Hold a redirect that arrived while memory was stalling the pipe.
    always_ff @(posedge clk) begin
        if (rst) begin
            redirect_pending <= 1'b0;
        end else if (mw && redirect_eff) begin
            redirect_pending <= 1'b1;
        end else if (redirect_accept) begin
            redirect_pending <= 1'b0;
        end
    end

    // Consecutive wait-cycle counter; parks at MEM_TIMEOUT, cleared when the wait ends.
    always_ff @(posedge clk) begin
        if (rst || !mw) begin
            wait_cnt <= '0;
        end else if (wait_cnt != WAIT_W'(MEM_TIMEOUT)) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
        end
    end

    // Sticky timeout flag, raised on the MEM_TIMEOUT-th consecutive wait cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_timeout_err <= 1'b0;
        end else if (mw && (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1))) begin
            mem_timeout_err <= 1'b1;
        end
    end

    sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
        .clk   (clk),
        .clear (rst),
        .inc   (ctl.pc_stall),
        .count (stall_cycles)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
        .clk   (clk),
        .clear (rst),
        .inc   (redirect_accept),
        .count (flush_events)
    );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - self-checking bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

    localparam int AW     = 5;
    localparam int CW     = 4;
    localparam int TMO    = 8;
    localparam int CNTMAX = 15;

    logic          clk;
    logic          rst;
    logic [AW-1:0] ID_Rs1_addr;
    logic [AW-1:0] ID_Rs2_addr;
    logic          ID_Rs1_used;
    logic          ID_Rs2_used;
    logic [AW-1:0] EX_Rd_addr;
    logic          EX_MemRead;
    logic          EX_Redirect;
    logic          MEM_dmem_req;
    logic          MEM_dmem_ack;
    logic          PC_stall;
    logic          IFID_stall;
    logic          IFID_flush;
    logic          IDEX_stall;
    logic          IDEX_flush;
    logic          EXMEM_stall;
    logic          mem_timeout_err;
    logic [CW-1:0] stall_cycles;
    logic [CW-1:0] flush_events;

    int n_cmp;
    int n_bad;

    // {PC_stall, IFID_stall, IFID_flush, IDEX_stall, IDEX_flush, EXMEM_stall}
    localparam logic [5:0] C_NONE  = 6'b000000;
    localparam logic [5:0] C_LU    = 6'b110010;
    localparam logic [5:0] C_WAIT  = 6'b110101;
    localparam logic [5:0] C_REDIR = 6'b001010;
    localparam logic [5:0] C_DRAIN = 6'b001000;

    logic [5:0] ctl;
    assign ctl = {PC_stall, IFID_stall, IFID_flush, IDEX_stall, IDEX_flush, EXMEM_stall};

    pipe_hazard_ctrl #(
        .REGFILE_ADDR_WIDTH (AW),
        .CNT_WIDTH          (CW),
        .MEM_TIMEOUT        (TMO),
        .REDIRECT_BUBBLES   (2)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .ID_Rs1_addr     (ID_Rs1_addr),
        .ID_Rs2_addr     (ID_Rs2_addr),
        .ID_Rs1_used     (ID_Rs1_used),
        .ID_Rs2_used     (ID_Rs2_used),
        .EX_Rd_addr      (EX_Rd_addr),
        .EX_MemRead      (EX_MemRead),
        .EX_Redirect     (EX_Redirect),
        .MEM_dmem_req    (MEM_dmem_req),
        .MEM_dmem_ack    (MEM_dmem_ack),
        .PC_stall        (PC_stall),
        .IFID_stall      (IFID_stall),
        .IFID_flush      (IFID_flush),
        .IDEX_stall      (IDEX_stall),
        .IDEX_flush      (IDEX_flush),
        .EXMEM_stall     (EXMEM_stall),
        .mem_timeout_err (mem_timeout_err),
        .stall_cycles    (stall_cycles),
        .flush_events    (flush_events)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ID_Rs1_addr  = '0;
        ID_Rs2_addr  = '0;
        ID_Rs1_used  = 1'b0;
        ID_Rs2_used  = 1'b0;
        EX_Rd_addr   = '0;
        EX_MemRead   = 1'b0;
        EX_Redirect  = 1'b0;
        MEM_dmem_req = 1'b0;
        MEM_dmem_ack = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic set_lw_x5_use();
        EX_MemRead  = 1'b1;
        EX_Rd_addr  = 5'd5;
        ID_Rs1_used = 1'b1;
        ID_Rs1_addr = 5'd5;
    endtask

    task automatic test_reset();
        idle_inputs();
        set_lw_x5_use();
        MEM_dmem_req = 1'b1;
        EX_Redirect  = 1'b1;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (ctl !== C_NONE) begin
            n_bad++;
            $display("FAIL reset_ctl: got %b want %b", ctl, C_NONE);
        end
        tick();
        n_cmp++;
        if (stall_cycles !== '0 || flush_events !== '0 || mem_timeout_err !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_regs: got stall=%0d flush=%0d err=%b want 0/0/0",
                     stall_cycles, flush_events, mem_timeout_err);
        end
        rst = 1'b0;
        idle_inputs();
    endtask

    task automatic test_load_use();
        do_reset();
        set_lw_x5_use();
        #1;
        n_cmp++;
        if (ctl !== C_LU) begin
            n_bad++;
            $display("FAIL lu_stall: got %b want %b", ctl, C_LU);
        end
        tick();
        EX_MemRead = 1'b0;
        #1;
        n_cmp++;
        if (ctl !== C_NONE || stall_cycles !== 4'd1) begin
            n_bad++;
            $display("FAIL lu_release: got ctl=%b stall=%0d want %b/1", ctl, stall_cycles, C_NONE);
        end
        tick();
        EX_MemRead  = 1'b1;
        EX_Rd_addr  = 5'd0;
        ID_Rs1_addr = 5'd0;
        ID_Rs2_used = 1'b1;
        ID_Rs2_addr = 5'd0;
        #1;
        n_cmp++;
        if (ctl !== C_NONE) begin
            n_bad++;
            $display("FAIL lu_x0: got %b want %b", ctl, C_NONE);
        end
        EX_Rd_addr  = 5'd7;
        ID_Rs1_addr = 5'd3;
        ID_Rs2_addr = 5'd7;
        #1;
        n_cmp++;
        if (ctl !== C_LU) begin
            n_bad++;
            $display("FAIL lu_rs2: got %b want %b", ctl, C_LU);
        end
        idle_inputs();
    endtask

    task automatic test_mem_wait();
        do_reset();
        MEM_dmem_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_cmp++;
            if (ctl !== C_WAIT) begin
                n_bad++;
                $display("FAIL wait_cycle%0d: got %b want %b", i, ctl, C_WAIT);
            end
            tick();
        end
        MEM_dmem_ack = 1'b1;
        #1;
        n_cmp++;
        if (ctl !== C_NONE) begin
            n_bad++;
            $display("FAIL wait_ack: got %b want %b", ctl, C_NONE);
        end
        tick();
        idle_inputs();
        set_lw_x5_use();
        #1;
        n_cmp++;
        if (stall_cycles !== 4'd4 || ctl !== C_LU) begin
            n_bad++;
            $display("FAIL wait_after: got stall=%0d ctl=%b want 4/%b", stall_cycles, ctl, C_LU);
        end
        idle_inputs();
    endtask

    task automatic test_redirect();
        do_reset();
        EX_Redirect = 1'b1;
        #1;
        n_cmp++;
        if (ctl !== C_REDIR) begin
            n_bad++;
            $display("FAIL redir_c0: got %b want %b", ctl, C_REDIR);
        end
        tick();
        EX_Redirect = 1'b0;
        set_lw_x5_use();
        #1;
        n_cmp++;
        if (ctl !== C_DRAIN) begin
            n_bad++;
            $display("FAIL redir_c1: got %b want %b", ctl, C_DRAIN);
        end
        tick();
        idle_inputs();
        #1;
        n_cmp++;
        if (ctl !== C_NONE || flush_events !== 4'd1) begin
            n_bad++;
            $display("FAIL redir_c2: got ctl=%b flush=%0d want %b/1", ctl, flush_events, C_NONE);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        EX_Redirect = 1'b1;
        tick();
        #1;
        n_cmp++;
        if (ctl !== C_REDIR) begin
            n_bad++;
            $display("FAIL b2b_redir: got %b want %b", ctl, C_REDIR);
        end
        tick();
        EX_Redirect = 1'b0;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (ctl !== C_NONE) begin
            n_bad++;
            $display("FAIL rst_in_drain: got %b want %b", ctl, C_NONE);
        end
        tick();
        rst = 1'b0;
        #1;
        n_cmp++;
        if (ctl !== C_NONE || flush_events !== 4'd0) begin
            n_bad++;
            $display("FAIL after_rst_drain: got ctl=%b flush=%0d want %b/0", ctl, flush_events, C_NONE);
        end
    endtask

    task automatic test_redirect_during_wait();
        do_reset();
        MEM_dmem_req = 1'b1;
        EX_Redirect  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++;
            if (ctl !== C_WAIT) begin
                n_bad++;
                $display("FAIL rw_wait%0d: got %b want %b", i, ctl, C_WAIT);
            end
            tick();
            EX_Redirect = (i == 0);
        end
        MEM_dmem_ack = 1'b1;
        #1;
        n_cmp++;
        if (ctl !== C_REDIR) begin
            n_bad++;
            $display("FAIL rw_ack: got %b want %b", ctl, C_REDIR);
        end
        tick();
        idle_inputs();
        #1;
        n_cmp++;
        if (ctl !== C_DRAIN || flush_events !== 4'd1) begin
            n_bad++;
            $display("FAIL rw_drain: got ctl=%b flush=%0d want %b/1", ctl, flush_events, C_DRAIN);
        end
        tick();
    endtask

    task automatic test_timeout();
        do_reset();
        MEM_dmem_req = 1'b1;
        for (int i = 1; i <= TMO; i++) begin
            #1;
            n_cmp++;
            if (mem_timeout_err !== 1'b0) begin
                n_bad++;
                $display("FAIL tmo_early%0d: got %b want 0", i, mem_timeout_err);
            end
            tick();
        end
        #1;
        n_cmp++;
        if (mem_timeout_err !== 1'b1 || ctl !== C_WAIT) begin
            n_bad++;
            $display("FAIL tmo_set: got err=%b ctl=%b want 1/%b", mem_timeout_err, ctl, C_WAIT);
        end
        MEM_dmem_ack = 1'b1;
        tick();
        tick();
        n_cmp++;
        if (mem_timeout_err !== 1'b1) begin
            n_bad++;
            $display("FAIL tmo_sticky: got %b want 1", mem_timeout_err);
        end
        MEM_dmem_ack = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle_inputs();
        set_lw_x5_use();
        #1;
        n_cmp++;
        if (mem_timeout_err !== 1'b0 || ctl !== C_LU) begin
            n_bad++;
            $display("FAIL tmo_clear: got err=%b ctl=%b want 0/%b", mem_timeout_err, ctl, C_LU);
        end
        idle_inputs();
    endtask

    task automatic test_saturation();
        do_reset();
        set_lw_x5_use();
        for (int i = 0; i < 20; i++) tick();
        n_cmp++;
        if (stall_cycles !== 4'd15) begin
            n_bad++;
            $display("FAIL stall_sat: got %0d want 15", stall_cycles);
        end
        idle_inputs();
    endtask

    // Reference: what each stage must do this cycle, from the hazard rules alone.
    task automatic test_random();
        bit m_drain_due;
        bit m_redir_owed;
        int m_wait_len;
        bit m_err;
        int m_stalls;
        int m_flushes;
        bit waiting;
        bit redir;
        bit hazard;
        logic [5:0] exp;

        do_reset();
        m_drain_due = 0; m_redir_owed = 0; m_wait_len = 0; m_err = 0;
        m_stalls = 0; m_flushes = 0;
        for (int cyc = 0; cyc < 500; cyc++) begin
            ID_Rs1_addr  = AW'($urandom_range(0, 3));
            ID_Rs2_addr  = AW'($urandom_range(0, 3));
            ID_Rs1_used  = 1'($urandom_range(0, 1));
            ID_Rs2_used  = 1'($urandom_range(0, 1));
            EX_Rd_addr   = AW'($urandom_range(0, 3));
            EX_MemRead   = 1'($urandom_range(0, 1));
            EX_Redirect  = ($urandom_range(0, 5) == 0);
            MEM_dmem_req = ($urandom_range(0, 2) == 0) || (m_wait_len > 0 && $urandom_range(0, 9) != 0);
            MEM_dmem_ack = ($urandom_range(0, 3) == 0);
            rst          = ($urandom_range(0, 59) == 0);

            waiting = MEM_dmem_req && !MEM_dmem_ack;
            redir   = EX_Redirect || m_redir_owed;
            hazard  = EX_MemRead && EX_Rd_addr != 0 &&
                      ((ID_Rs1_used && ID_Rs1_addr == EX_Rd_addr) ||
                       (ID_Rs2_used && ID_Rs2_addr == EX_Rd_addr));
            if (rst)              exp = C_NONE;
            else if (waiting)     exp = C_WAIT;
            else if (redir)       exp = C_REDIR;
            else if (m_drain_due) exp = C_DRAIN;
            else if (hazard)      exp = C_LU;
            else                  exp = C_NONE;

            #1;
            n_cmp++;
            if (ctl !== exp) begin
                n_bad++;
                $display("FAIL rnd_ctl@%0d: got %b want %b", cyc, ctl, exp);
            end
            n_cmp++;
            if (mem_timeout_err !== m_err) begin
                n_bad++;
                $display("FAIL rnd_err@%0d: got %b want %b", cyc, mem_timeout_err, m_err);
            end
            n_cmp++;
            if (int'(stall_cycles) !== m_stalls || int'(flush_events) !== m_flushes) begin
                n_bad++;
                $display("FAIL rnd_cnt@%0d: got stall=%0d flush=%0d want %0d/%0d",
                         cyc, stall_cycles, flush_events, m_stalls, m_flushes);
            end
            tick();

            if (rst) begin
                m_drain_due = 0; m_redir_owed = 0; m_wait_len = 0; m_err = 0;
                m_stalls = 0; m_flushes = 0;
            end else begin
                if (exp[5] && m_stalls < CNTMAX) m_stalls++;
                if (waiting) begin
                    m_wait_len++;
                    if (m_wait_len >= TMO) m_err = 1;
                    if (redir) m_redir_owed = 1;
                    m_drain_due = 0;
                end else begin
                    m_wait_len = 0;
                    if (redir) begin
                        if (m_flushes < CNTMAX) m_flushes++;
                        m_redir_owed = 0;
                        m_drain_due  = 1;
                    end else begin
                        m_drain_due = 0;
                    end
                end
            end
        end
        rst = 1'b0;
        idle_inputs();
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst   = 1'b1;
        idle_inputs();
        tick();
        test_reset();
        test_load_use();
        test_mem_wait();
        test_redirect();
        test_back_to_back();
        test_redirect_during_wait();
        test_timeout();
        test_saturation();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
